// File: rtl/aes_pkg.sv
// Shared AES definitions: byte/word/key types, the round-constant table,
// the forward S-box table, the inverse key-schedule FSM states, and
// word extract/pack helpers (word 0 sits in bits [127:96]).
// Build option: AES_INV_KS_REG_SBOX_EN adds the SUB state.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] key_t;

    localparam int AES128_NR = 10;

    // Round constants, indexed by round number 1..10.
    localparam byte_t RCON_TAB [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Forward AES S-box.
    localparam byte_t AES_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Inverse key-schedule controller states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OUT  = 3'd1,
        ST_CALC = 3'd2,
        ST_DONE = 3'd3
`ifdef AES_INV_KS_REG_SBOX_EN
        ,
        ST_SUB  = 3'd4
`endif
    } ks_state_e;

    // Round constant for round r; zero outside 1..10.
    function automatic byte_t get_rcon(input logic [3:0] r);
        byte_t v;
        v = 8'h00;
        if (r >= 4'd1 && r <= 4'd10) begin
            v = RCON_TAB[r];
        end
        return v;
    endfunction

    // Word i of a 128-bit key, word 0 = bits [127:96].
    function automatic word_t get_word(input key_t k, input logic [1:0] i);
        word_t w;
        case (i)
            2'd0:    w = k[127:96];
            2'd1:    w = k[95:64];
            2'd2:    w = k[63:32];
            default: w = k[31:0];
        endcase
        return w;
    endfunction

    // Pack four words back into key byte order.
    function automatic key_t pack_words(input word_t w0, input word_t w1,
                                        input word_t w2, input word_t w3);
        return {w0, w1, w2, w3};
    endfunction

    // Cyclic left rotate by one byte.
    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_inv_ks_step.sv
// One backward step of the AES-128 key schedule. Given round key r
// (words c0..c3) and rcon[r], produces round key r-1:
//   p3 = c3^c2, p2 = c2^c1, p1 = c1^c0,
//   p0 = c0 ^ SubWord(i_sbox_in) ^ {rcon,00,00,00}
// The S-box input is a port so the parent can either feed o_rot_word
// straight back (single-cycle step) or register it first.
module aes_inv_ks_step
    import aes_pkg::*;
(
    input  logic [127:0] i_key,
    input  logic [7:0]   i_rcon,
    input  logic [31:0]  i_sbox_in,
    output logic [31:0]  o_rot_word,
    output logic [127:0] o_prev_key
);

    logic [31:0] w_c0, w_c1, w_c2, w_c3;
    logic [31:0] w_p0, w_p1, w_p2, w_p3;
    logic [31:0] w_sub;

    assign w_c0 = get_word(i_key, 2'd0);
    assign w_c1 = get_word(i_key, 2'd1);
    assign w_c2 = get_word(i_key, 2'd2);
    assign w_c3 = get_word(i_key, 2'd3);

    assign w_p3 = w_c3 ^ w_c2;
    assign w_p2 = w_c2 ^ w_c1;
    assign w_p1 = w_c1 ^ w_c0;

    assign o_rot_word = rot_word(w_p3);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (i_sbox_in[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign w_p0 = w_c0 ^ w_sub ^ {i_rcon, 24'h000000};

    assign o_prev_key = pack_words(w_p0, w_p1, w_p2, w_p3);

endmodule

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = AES_SBOX[i_byte];

endmodule

// File: rtl/aes_inv_key_sched.sv
// Streaming inverse AES-128 key schedule. Loads the round-10 key and
// emits round keys 10 down to 0, deriving each previous key on the fly.
// Build option: AES_INV_KS_REG_SBOX_EN registers the S-box input, adding
// a SUB state so every key gap is two invalid cycles instead of one.
//
// Handshake: o_round_key/o_round_idx are a transfer when o_key_valid and
// i_key_ready are both high on a rising edge; while o_key_valid is high
// and no transfer happens the outputs hold; i_key_ready has no effect
// while o_key_valid is low; o_key_valid never drops without a transfer.
module aes_inv_key_sched
    import aes_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [127:0] i_last_key,
    output logic [127:0] o_round_key,
    output logic [3:0]   o_round_idx,
    output logic         o_key_valid,
    input  logic         i_key_ready,
    output logic         o_busy,
    output logic         o_done,
    output ks_state_e    o_dbg_state
);

    localparam int NR = AES128_NR;

    ks_state_e    r_state;
    ks_state_e    w_next_state;
    logic [127:0] r_key;
    logic [3:0]   r_idx;
    logic         w_xfer;
    logic [7:0]   w_rcon;
    logic [31:0]  w_rot_word;
    logic [31:0]  w_sbox_in;
    logic [127:0] w_prev_key;

`ifdef AES_INV_KS_REG_SBOX_EN
    logic [31:0]  r_sbox_in;
    assign w_sbox_in = r_sbox_in;
`else
    assign w_sbox_in = w_rot_word;
`endif

    assign w_xfer = (r_state == ST_OUT) && i_key_ready;
    assign w_rcon = get_rcon(r_idx);

    aes_inv_ks_step u_step (
        .i_key      (r_key),
        .i_rcon     (w_rcon),
        .i_sbox_in  (w_sbox_in),
        .o_rot_word (w_rot_word),
        .o_prev_key (w_prev_key)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_next_state = r_state;
        o_key_valid  = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = ST_OUT;
                end
            end
            ST_OUT: begin
                o_key_valid = 1'b1;
                o_busy      = 1'b1;
                if (w_xfer) begin
                    w_next_state = (r_idx == 4'd0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                o_busy = 1'b1;
`ifdef AES_INV_KS_REG_SBOX_EN
                w_next_state = ST_SUB;
`else
                w_next_state = ST_OUT;
`endif
            end
`ifdef AES_INV_KS_REG_SBOX_EN
            ST_SUB: begin
                o_busy       = 1'b1;
                w_next_state = ST_OUT;
            end
`endif
            ST_DONE: begin
                o_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Key and round-index registers: load on start, step back one round.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_key <= '0;
            r_idx <= '0;
`ifdef AES_INV_KS_REG_SBOX_EN
            r_sbox_in <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_key <= i_last_key;
                        r_idx <= 4'(NR);
                    end
                end
`ifdef AES_INV_KS_REG_SBOX_EN
                ST_CALC: begin
                    r_sbox_in <= w_rot_word;
                end
                ST_SUB: begin
                    r_key <= w_prev_key;
                    r_idx <= r_idx - 4'd1;
                end
`else
                ST_CALC: begin
                    r_key <= w_prev_key;
                    r_idx <= r_idx - 4'd1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign o_round_key = r_key;
    assign o_round_idx = r_idx;
    assign o_dbg_state = r_state;

endmodule
